traffic_conflict_monitor: RTL
=============================

Name: traffic_conflict_monitor

Overview:
Safety stage directly downstream of the traffic light controller. It consumes the 2-bit ns/ew phase codes (green 2'b00, yellow 2'b01, red 2'b10) and drives one-hot lamp outputs. It also checks every cycle for conflicting, illegal, out-of-sequence, too-short and stuck phases. On any violation it latches a fault and forces flashing red on both approaches until cleared.

Parameters:
MIN_GREEN, 10, minimum cycles a green phase must be held before green->yellow.
MIN_YELLOW, 3, minimum cycles a yellow phase must be held before yellow->red.
MAX_PHASE, 20, cycles an unchanged ns/ew pair may persist before a stuck fault.
START_CYC, 2, all-red cycles after reset or fault clear before monitoring begins.
FLASH_HALF, 1, cycles per on/off half-period of the fault red flash.

Ports:
clk  input  1  clock, same clock as the controller.
rst  input  1  reset; asynchronous, active-low.
ns  input  2  north-south phase code from the controller.
ew  input  2  east-west phase code from the controller.
fault_clr  input  1  level; leave FAULT when high; ignored in other states.
ns_lamp  output  3  {red,yellow,green} north-south lamp drive, one-hot or all-off.
ew_lamp  output  3  {red,yellow,green} east-west lamp drive.
fault  output  1  high while in FAULT.
fault_code  output  3  reason for the latched fault; 0 when no fault.

Behaviour:
- Reset (rst low, async): state START; ns_lamp=ew_lamp=3'b100; fault=0; fault_code=0; prev_ns=prev_ew=2'b10; dwell=0; start counter=0; flash phase=on.
- dwell: counter wide enough for MAX_PHASE. It loads 1 on any cycle where {ns,ew} != {prev_ns,prev_ew}, otherwise increments and saturates at MAX_PHASE. prev_* registers sample ns/ew every cycle in all states.
- START: lamps all red (3'b100 each). Move to MON after START_CYC cycles. No checks in START.
- MON: lamps registered decode of the inputs, 1-cycle latency. Green maps to 001, yellow to 010, red to 100. Checks are evaluated combinationally on the current inputs and prev_*/dwell, in this priority order (lowest code wins on simultaneous violations):
  1. ILLEGAL: ns or ew == 2'b11.
  2. CONFLICT: ns != red and ew != red.
  3. BAD_SEQ: an approach changes other than green->yellow, yellow->red or red->green.
  4. SHORT_GREEN: green->yellow on an approach with dwell < MIN_GREEN.
  5. SHORT_YELLOW: yellow->red on an approach with dwell < MIN_YELLOW.
  6. STUCK: pair unchanged and dwell == MAX_PHASE.
- On a violation in cycle N, at edge N+1: state FAULT, fault=1, fault_code set. Lamps take the flash pattern at that same edge; the violating pair is never shown on the lamps.
- FAULT:
  - ns_lamp=ew_lamp={flash,0,0}. flash starts at 1 and toggles every FLASH_HALF cycles.
  - fault_code holds its value and further violations are ignored.
  - fault_clr high in any cycle: next edge goes to START with fault=0, fault_code=0, start counter=0 and lamps all red. The flash phase resets to on.
- Controller-nominal timing passes cleanly: green 11 cycles, yellow 4, approaches alternating.
- Reset asserted mid-operation, including in FAULT, returns immediately to the reset values.

Optional Feature:
CONFLICT_MON_STATS_EN:
- Defined: adds output fault_count (8 bits). It resets to 0 and increments by 1 on each entry into FAULT, saturating at 255. fault_clr does not clear it; only rst does.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Nominal cycle: drive ns/ew with controller timing (green 11, yellow 4, red) for 3 full cycles. Expect fault=0 throughout. Lamps follow the inputs 1 cycle late (e.g. ns=00 gives ns_lamp=001 next cycle). Both lamps are 100 for the first 2 cycles after reset.
- Conflict: in MON, drive ns=00, ew=00 for one cycle. Expect fault=1, fault_code=2 next edge, and both lamps 100. Lamps then alternate 100/000 every cycle.
- Short green: ns green held 5 cycles, then yellow. Expect fault_code=4. Simultaneous ns=11 with the same transition: expect fault_code=1 (priority).
- Stuck: hold ns=00, ew=10 for 20 cycles. Expect fault_code=6 at edge after dwell reaches 20.
- Clear and reset: in FAULT, pulse fault_clr for one cycle. Expect fault=0, code 0, lamps 100 for 2 cycles, then MON. Assert rst low mid-flash: lamps 100 and fault=0 asynchronously.
- With CONFLICT_MON_STATS_EN: trigger 3 faults with clears in between. Expect fault_count=3, unchanged by fault_clr, and 0 after rst.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Purpose : safety check between the light controller and the lamps; a violation latches a fault and flashes red on both approaches.
// Latency : lamps are a 1-cycle registered decode of ns/ew; a violation seen in cycle N shows as fault/fault_code/flash at edge N+1.
// Backpressure: none; one phase pair is consumed every cycle and the outputs are always valid.
//
// Ports:
//   clk        clock shared with the controller
//   rst        asynchronous active-low reset
//   ns, ew     phase codes: green 2'b00, yellow 2'b01, red 2'b10 (2'b11 is illegal)
//   fault_clr  level; leaves FAULT for START when high, ignored otherwise
//   ns_lamp    {red,yellow,green} north-south lamp drive
//   ew_lamp    {red,yellow,green} east-west lamp drive
//   fault      high while in FAULT
//   fault_code 1 illegal, 2 conflict, 3 bad sequence, 4 short green,
//              5 short yellow, 6 stuck; 0 when no fault
//   fault_count (only with CONFLICT_MON_STATS_EN) saturating count of FAULT entries
//
// Optional feature macro: CONFLICT_MON_STATS_EN adds the fault_count output.

module traffic_conflict_monitor #(
    parameter int MIN_GREEN  = 10,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_PHASE  = 20,
    parameter int START_CYC  = 2,
    parameter int FLASH_HALF = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ns,
    input  logic [1:0] ew,
    input  logic       fault_clr,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef CONFLICT_MON_STATS_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam logic [1:0] PH_GRN = 2'b00;
    localparam logic [1:0] PH_YEL = 2'b01;
    localparam logic [1:0] PH_RED = 2'b10;
    localparam logic [1:0] PH_ILL = 2'b11;

    localparam logic [2:0] LAMP_RED = 3'b100;

    localparam logic [2:0] CODE_NONE      = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL   = 3'd1;
    localparam logic [2:0] CODE_CONFLICT  = 3'd2;
    localparam logic [2:0] CODE_BAD_SEQ   = 3'd3;
    localparam logic [2:0] CODE_SHORT_GRN = 3'd4;
    localparam logic [2:0] CODE_SHORT_YEL = 3'd5;
    localparam logic [2:0] CODE_STUCK     = 3'd6;

    localparam int DW  = $clog2(MAX_PHASE + 1);
    localparam int SCW = $clog2(START_CYC + 1);
    localparam int FCW = $clog2(FLASH_HALF + 1);

    localparam logic [DW-1:0]  MAX_P   = DW'(MAX_PHASE);
    localparam logic [DW-1:0]  MIN_G   = DW'(MIN_GREEN);
    localparam logic [DW-1:0]  MIN_Y   = DW'(MIN_YELLOW);
    localparam logic [SCW-1:0] SC_LAST = SCW'(START_CYC - 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_MON   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [1:0]     prev_ns;
    logic [1:0]     prev_ew;
    logic [DW-1:0]  dwell;
    logic [SCW-1:0] start_cnt;
    logic [SCW-1:0] start_cnt_nxt;
    logic           flash;
    logic           flash_nxt;
    logic [FCW-1:0] flash_cnt;
    logic [FCW-1:0] flash_cnt_nxt;
    logic [2:0]     ns_lamp_nxt;
    logic [2:0]     ew_lamp_nxt;
    logic [2:0]     code_nxt;

    logic           pair_same;
    logic           grn_to_yel;
    logic           yel_to_red;
    logic [2:0]     viol_code;

    // An approach may hold its phase or advance one step around green->yellow->red->green.
    function automatic logic seq_ok(input logic [1:0] p, input logic [1:0] c);
        return (c == p) ||
               (p == PH_GRN && c == PH_YEL) ||
               (p == PH_YEL && c == PH_RED) ||
               (p == PH_RED && c == PH_GRN);
    endfunction

    function automatic logic [2:0] lamp_decode(input logic [1:0] ph);
        case (ph)
            PH_GRN:  return 3'b001;
            PH_YEL:  return 3'b010;
            PH_RED:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Violation detection on the live inputs; the if/else chain encodes priority.
    always_comb begin
        pair_same  = ({ns, ew} == {prev_ns, prev_ew});
        grn_to_yel = (prev_ns == PH_GRN && ns == PH_YEL) || (prev_ew == PH_GRN && ew == PH_YEL);
        yel_to_red = (prev_ns == PH_YEL && ns == PH_RED) || (prev_ew == PH_YEL && ew == PH_RED);
        viol_code  = CODE_NONE;
        if (ns == PH_ILL || ew == PH_ILL)
            viol_code = CODE_ILLEGAL;
        else if (ns != PH_RED && ew != PH_RED)
            viol_code = CODE_CONFLICT;
        else if (!seq_ok(prev_ns, ns) || !seq_ok(prev_ew, ew))
            viol_code = CODE_BAD_SEQ;
        else if (grn_to_yel && dwell < MIN_G)
            viol_code = CODE_SHORT_GRN;
        else if (yel_to_red && dwell < MIN_Y)
            viol_code = CODE_SHORT_YEL;
        else if (pair_same && dwell == MAX_P)
            viol_code = CODE_STUCK;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_START;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_START: if (start_cnt == SC_LAST)     state_nxt = ST_MON;
            ST_MON:   if (viol_code != CODE_NONE)   state_nxt = ST_FAULT;
            ST_FAULT: if (fault_clr)                state_nxt = ST_START;
            default:                                state_nxt = ST_START;
        endcase
    end

    // Output logic: next values of the registered lamp/code/flash/start state
    always_comb begin
        start_cnt_nxt = start_cnt;
        flash_nxt     = flash;
        flash_cnt_nxt = flash_cnt;
        code_nxt      = fault_code;
        ns_lamp_nxt   = LAMP_RED;
        ew_lamp_nxt   = LAMP_RED;
        unique case (state)
            ST_START: begin
                start_cnt_nxt = (start_cnt == SC_LAST) ? '0 : start_cnt + 1'b1;
            end
            ST_MON: begin
                if (viol_code != CODE_NONE) begin
                    // Flash begins in the on phase, so the offending pair never reaches the lamps.
                    code_nxt      = viol_code;
                    flash_nxt     = 1'b1;
                    flash_cnt_nxt = '0;
                end else begin
                    ns_lamp_nxt = lamp_decode(ns);
                    ew_lamp_nxt = lamp_decode(ew);
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    code_nxt      = CODE_NONE;
                    flash_nxt     = 1'b1;
                    flash_cnt_nxt = '0;
                    start_cnt_nxt = '0;
                end else begin
                    if (flash_cnt == FC_LAST) begin
                        flash_nxt     = ~flash;
                        flash_cnt_nxt = '0;
                    end else begin
                        flash_cnt_nxt = flash_cnt + 1'b1;
                    end
                    ns_lamp_nxt = {flash_nxt, 2'b00};
                    ew_lamp_nxt = {flash_nxt, 2'b00};
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; prev_* and dwell track the inputs in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_ns    <= PH_RED;
            prev_ew    <= PH_RED;
            dwell      <= '0;
            start_cnt  <= '0;
            flash      <= 1'b1;
            flash_cnt  <= '0;
            ns_lamp    <= LAMP_RED;
            ew_lamp    <= LAMP_RED;
            fault_code <= CODE_NONE;
        end else begin
            prev_ns    <= ns;
            prev_ew    <= ew;
            if (!pair_same)
                dwell <= DW'(1);
            else if (dwell != MAX_P)
                dwell <= dwell + 1'b1;
            start_cnt  <= start_cnt_nxt;
            flash      <= flash_nxt;
            flash_cnt  <= flash_cnt_nxt;
            ns_lamp    <= ns_lamp_nxt;
            ew_lamp    <= ew_lamp_nxt;
            fault_code <= code_nxt;
        end
    end

    assign fault = (state == ST_FAULT);

`ifdef CONFLICT_MON_STATS_EN
    // Counts FAULT entries; survives fault_clr, cleared only by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fault_count <= 8'd0;
        else if (state == ST_MON && viol_code != CODE_NONE && fault_count != 8'hFF)
            fault_count <= fault_count + 8'd1;
    end
`endif

endmodule
